// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 encodings, master FSM states and burst geometry helpers.
package axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } t_axi_burst;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP
    } t_master_state;

    // Number of data beats needed to move one block
    function automatic int unsigned burst_beats(input int unsigned block_width,
                                                input int unsigned data_width);
        return block_width / data_width;
    endfunction

    // AxSIZE encoding for a given beat width in bits
    function automatic int unsigned burst_size(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 INCR burst initiator for cache line fills and dirty write-backs.
// Build macro AXI_MASTER_RESP_CHECK_EN enables error reporting on o_error
// (non-OKAY responses or R_LAST not on the final beat); otherwise o_error is 0.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BLOCK_WIDTH    = 512
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic                        i_start_read,
    input  logic                        i_start_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
    input  logic [BLOCK_WIDTH-1:0]      i_data,
    output logic [BLOCK_WIDTH-1:0]      o_data,
    output logic                        o_done,
    output logic                        o_busy,
    output logic                        o_error,
    output logic                        AR_VALID,
    input  logic                        AR_READY,
    output logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
    output logic [7:0]                  AR_LEN,
    output logic [2:0]                  AR_SIZE,
    output logic [1:0]                  AR_BURST,
    output logic [2:0]                  AR_PROT,
    input  logic [AXI_DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]                  R_RESP,
    input  logic                        R_LAST,
    input  logic                        R_VALID,
    output logic                        R_READY,
    output logic                        AW_VALID,
    input  logic                        AW_READY,
    output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
    output logic [7:0]                  AW_LEN,
    output logic [2:0]                  AW_SIZE,
    output logic [1:0]                  AW_BURST,
    output logic [2:0]                  AW_PROT,
    output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
    output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
    output logic                        W_LAST,
    output logic                        W_VALID,
    input  logic                        W_READY,
    input  logic [1:0]                  B_RESP,
    input  logic                        B_VALID,
    output logic                        B_READY
);

    localparam int unsigned BEATS = burst_beats(BLOCK_WIDTH, AXI_DATA_WIDTH);
    localparam int unsigned CW    = $clog2(BEATS) + 1;
    localparam int unsigned OFF   = $clog2(BLOCK_WIDTH / 8);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(BEATS);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_MASK = {AXI_ADDR_WIDTH{1'b1}} << OFF;
    localparam logic [7:0] LEN  = 8'(BEATS - 1);
    localparam logic [2:0] SIZE = 3'(burst_size(AXI_DATA_WIDTH));

    t_master_state             state_q;
    logic [CW-1:0]             cnt_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [BLOCK_WIDTH-1:0]    blk_q, blk_d, rdata_q;
    logic [AXI_DATA_WIDTH-1:0] wbeat_d;
    logic done_q, busy_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic r_hs, w_hs, b_hs;

    assign r_hs = rready_q & R_VALID;
    assign w_hs = wvalid_q & W_READY;
    assign b_hs = bready_q & B_VALID;

    // Block buffer next value: write block captured at start, read beats merged by slot
    always_comb begin
        blk_d = blk_q;
        if (state_q == ST_IDLE && i_start_write) begin
            blk_d = i_data;
        end else if (r_hs) begin
            // beats past the last slot match nothing and are dropped
            for (int unsigned b = 0; b < BEATS; b++) begin
                if (cnt_q == CW'(b)) blk_d[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = R_DATA;
            end
        end
    end

    // Current write beat selected from the latched block by the beat counter
    always_comb begin
        wbeat_d = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CW'(b)) wbeat_d = blk_q[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        end
    end

    // Transaction sequencer: handshake outputs, beat counter, address and read result
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            blk_q     <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            blk_q  <= blk_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start_write) begin
                        addr_q    <= i_addr & ADDR_MASK;
                        awvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_WADDR;
                    end else if (i_start_read) begin
                        addr_q    <= i_addr & ADDR_MASK;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_RADDR;
                    end
                end
                ST_RADDR: begin
                    if (AR_READY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        if (cnt_q != MAX_CNT) cnt_q <= cnt_q + CW'(1);
                        if (R_LAST) begin
                            rready_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            rdata_q  <= blk_d;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_WADDR: begin
                    if (AW_READY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= ST_WRESP;
                        end
                    end
                end
                ST_WRESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_MASTER_RESP_CHECK_EN
    logic err_q;

    // Sticky per-transaction error, cleared when the next request is accepted
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && (i_start_write || i_start_read)) begin
            err_q <= 1'b0;
        end else if (r_hs && (R_RESP != OKAY || R_LAST != (cnt_q == LAST_CNT))) begin
            err_q <= 1'b1;
        end else if (b_hs && B_RESP != OKAY) begin
            err_q <= 1'b1;
        end
    end

    assign o_error = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{R_RESP, B_RESP};
    assign o_error     = 1'b0;
`endif

    assign o_data   = rdata_q;
    assign o_done   = done_q;
    assign o_busy   = busy_q;

    assign AR_VALID = arvalid_q;
    assign AR_ADDR  = addr_q;
    assign AR_LEN   = LEN;
    assign AR_SIZE  = SIZE;
    assign AR_BURST = INCR;
    assign AR_PROT  = '0;
    assign R_READY  = rready_q;

    assign AW_VALID = awvalid_q;
    assign AW_ADDR  = addr_q;
    assign AW_LEN   = LEN;
    assign AW_SIZE  = SIZE;
    assign AW_BURST = INCR;
    assign AW_PROT  = '0;
    assign W_DATA   = wbeat_d;
    assign W_STRB   = '1;
    assign W_LAST   = wvalid_q && (cnt_q == LAST_CNT);
    assign W_VALID  = wvalid_q;
    assign B_READY  = bready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed + randomized bench for axi_burst_master with an
// in-bench AXI slave and a block-level reference model.
module tb_axi_burst_master;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 512;
    localparam int unsigned NB = BW / DW;
    localparam int unsigned NONE = 999;

    logic          clk = 1'b0;
    logic          arstn = 1'b1;
    logic          i_start_read = 1'b0, i_start_write = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [BW-1:0] i_data = '0;
    logic [BW-1:0] o_data;
    logic          o_done, o_busy, o_error;
    logic          AR_VALID, AR_READY = 1'b0;
    logic [AW-1:0] AR_ADDR;
    logic [7:0]    AR_LEN;
    logic [2:0]    AR_SIZE, AR_PROT;
    logic [1:0]    AR_BURST;
    logic [DW-1:0] R_DATA = '0;
    logic [1:0]    R_RESP = '0;
    logic          R_LAST = 1'b0, R_VALID = 1'b0, R_READY;
    logic          AW_VALID, AW_READY = 1'b0;
    logic [AW-1:0] AW_ADDR;
    logic [7:0]    AW_LEN;
    logic [2:0]    AW_SIZE, AW_PROT;
    logic [1:0]    AW_BURST;
    logic [DW-1:0] W_DATA;
    logic [DW/8-1:0] W_STRB;
    logic          W_LAST, W_VALID, W_READY = 1'b0;
    logic [1:0]    B_RESP = '0;
    logic          B_VALID = 1'b0, B_READY;

    int unsigned   cyc = 0;
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [DW-1:0] rd_words [0:31];
    logic [BW-1:0] last_rd = '0;
    logic          last_rd_known = 1'b1;

    axi_burst_master #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .BLOCK_WIDTH   (BW)
    ) dut (
        .clk(clk), .arstn(arstn),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_addr(i_addr), .i_data(i_data), .o_data(o_data),
        .o_done(o_done), .o_busy(o_busy), .o_error(o_error),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN),
        .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST), .AR_PROT(AR_PROT),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST), .R_VALID(R_VALID), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN),
        .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST), .AW_PROT(AW_PROT),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_LAST(W_LAST), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected error flag for a read whose R_LAST comes on beat last_idx and
    // whose beat bad_idx (if sent) carries SLVERR
    function automatic logic exp_err_read(input int unsigned last_idx, input int unsigned bad_idx);
`ifdef AXI_MASTER_RESP_CHECK_EN
        return (last_idx != NB - 1) || (bad_idx <= last_idx);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_err_write(input logic [1:0] bresp);
`ifdef AXI_MASTER_RESP_CHECK_EN
        return bresp != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int unsigned k = 0; k < NB; k++) b[k*DW +: DW] = $urandom;
        return b;
    endfunction

    task automatic fill_words();
        for (int unsigned k = 0; k < 32; k++) rd_words[k] = $urandom;
    endtask

    // Read transaction from the slave side; abort_at asserts reset on that beat
    task automatic do_read(input logic [AW-1:0] addr, input int unsigned ar_wait,
                           input int unsigned max_gap, input int unsigned last_idx,
                           input int unsigned bad_idx, input int unsigned abort_at,
                           output int unsigned done_cyc);
        int unsigned   t0;
        logic [BW-1:0] exp_blk;
        t0 = cyc;
        done_cyc = 0;
        i_addr = addr;
        i_start_read = 1'b1;
        tick();
        i_start_read = 1'b0;
        i_addr = {$urandom, $urandom};
        chk("ar_valid", AR_VALID, 1);
        chk("ar_addr", AR_ADDR, (addr >> 6) << 6);
        chk("ar_len", AR_LEN, NB - 1);
        chk("ar_size", AR_SIZE, $clog2(DW / 8));
        chk("ar_burst", AR_BURST, 2'b01);
        chk("ar_prot", AR_PROT, 3'b000);
        chk("aw_quiet_rd", AW_VALID, 0);
        for (int unsigned w = 0; w < ar_wait; w++) begin
            tick();
            chk("ar_hold", AR_VALID, 1);
            chk("ar_addr_hold", AR_ADDR, (addr >> 6) << 6);
        end
        AR_READY = 1'b1;
        tick();
        AR_READY = 1'b0;
        chk("ar_drop", AR_VALID, 0);
        for (int unsigned k = 0; k <= last_idx; k++) begin
            if (max_gap != 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    R_VALID = 1'b0;
                    chk("r_ready_gap", R_READY, 1);
                    tick();
                end
            end
            R_VALID = 1'b1;
            R_DATA  = rd_words[k];
            R_LAST  = (k == last_idx);
            R_RESP  = (k == bad_idx) ? 2'b10 : 2'b00;
            chk("r_ready", R_READY, 1);
            if (k == abort_at) begin
                arstn = 1'b0;
                #1;
                chk("rst_handshakes", {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}, 0);
                chk("rst_status", {o_busy, o_done, o_error}, 0);
                chk_blk("rst_o_data", o_data, '0);
                R_VALID = 1'b0;
                R_LAST  = 1'b0;
                R_RESP  = 2'b00;
                tick();
                chk("rst_held_idle", {AR_VALID, R_READY, o_busy}, 0);
                arstn = 1'b1;
                tick();
                last_rd = '0;
                last_rd_known = 1'b1;
                return;
            end
            tick();
        end
        R_VALID = 1'b0;
        R_LAST  = 1'b0;
        R_RESP  = 2'b00;
        done_cyc = cyc - t0;
        for (int unsigned k = 0; k < NB; k++) exp_blk[k*DW +: DW] = rd_words[k];
        chk("rd_done", o_done, 1);
        chk("rd_busy_end", o_busy, 0);
        chk("rd_ready_end", R_READY, 0);
        chk("rd_error", o_error, exp_err_read(last_idx, bad_idx));
        if (last_idx >= NB - 1) begin
            chk_blk("rd_o_data", o_data, exp_blk);
            last_rd = exp_blk;
            last_rd_known = 1'b1;
        end else begin
            last_rd_known = 1'b0;
        end
        tick();
        chk("rd_done_pulse", o_done, 0);
    endtask

    // Write transaction; wmode 0=always ready, 1=toggle 1/0, 2=random.
    // hold_read keeps i_start_read high throughout; poke_cyc pulses it once in WDATA.
    task automatic do_write(input logic [AW-1:0] addr, input logic [BW-1:0] blk,
                            input int unsigned aw_wait, input int unsigned wmode,
                            input logic [1:0] bresp, input logic hold_read,
                            input int unsigned poke_cyc, output int unsigned done_cyc);
        int unsigned t0, beat, guard;
        logic wr;
        t0 = cyc;
        i_addr = addr;
        i_data = blk;
        i_start_write = 1'b1;
        if (hold_read) i_start_read = 1'b1;
        tick();
        i_start_write = 1'b0;
        i_data = rand_block();
        i_addr = {$urandom, $urandom};
        chk("aw_valid", AW_VALID, 1);
        chk("aw_addr", AW_ADDR, (addr >> 6) << 6);
        chk("aw_len", AW_LEN, NB - 1);
        chk("aw_size", AW_SIZE, $clog2(DW / 8));
        chk("aw_burst", AW_BURST, 2'b01);
        chk("aw_prot", AW_PROT, 3'b000);
        chk("ar_quiet_aw", AR_VALID, 0);
        for (int unsigned w = 0; w < aw_wait; w++) begin
            tick();
            chk("aw_hold", AW_VALID, 1);
            chk("w_before_aw", W_VALID, 0);
        end
        AW_READY = 1'b1;
        tick();
        AW_READY = 1'b0;
        chk("aw_drop", AW_VALID, 0);
        beat = 0;
        guard = 0;
        while (beat < NB && guard < 400) begin
            case (wmode)
                0:       wr = 1'b1;
                1:       wr = (guard % 2) == 0;
                default: wr = 1'($urandom_range(0, 1));
            endcase
            W_READY = wr;
            if (guard == poke_cyc) i_start_read = 1'b1;
            else if (!hold_read)   i_start_read = 1'b0;
            chk("w_valid", W_VALID, 1);
            chk("w_data", W_DATA, blk[beat*DW +: DW]);
            chk("w_last", W_LAST, beat == NB - 1);
            chk("w_strb", W_STRB, 4'hF);
            chk("ar_quiet_w", AR_VALID, 0);
            if (wr) beat++;
            tick();
            guard++;
        end
        W_READY = 1'b0;
        if (!hold_read) i_start_read = 1'b0;
        if (beat < NB) chk("w_timeout", beat, NB);
        chk("w_valid_end", W_VALID, 0);
        chk("b_ready", B_READY, 1);
        chk("ar_quiet_b", AR_VALID, 0);
        B_VALID = 1'b1;
        B_RESP  = bresp;
        tick();
        B_VALID = 1'b0;
        B_RESP  = 2'b00;
        done_cyc = cyc - t0;
        chk("wr_done", o_done, 1);
        chk("wr_busy_end", o_busy, 0);
        chk("wr_error", o_error, exp_err_write(bresp));
        if (last_rd_known) chk_blk("o_data_hold", o_data, last_rd);
    endtask

    initial begin
        int unsigned   dc;
        logic [BW-1:0] blk;

        // reset state
        #2 arstn = 1'b0;
        repeat (3) tick();
        chk("reset_handshakes", {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}, 0);
        chk("reset_status", {o_busy, o_done, o_error}, 0);
        chk_blk("reset_o_data", o_data, '0);
        arstn = 1'b1;
        tick();

        // basic read, slave always ready, beat k carries k
        for (int unsigned k = 0; k < 32; k++) rd_words[k] = k;
        do_read(64'h1044, 0, 0, NB - 1, NONE, NONE, dc);
        chk("rd_latency", dc, 18);

        // write with AW stalled 3 cycles, W_READY toggling, read request poked mid-burst
        for (int unsigned k = 0; k < NB; k++) blk[k*DW +: DW] = 32'hA5A5_A500 | k;
        do_write(64'h2000_0013, blk, 3, 1, 2'b00, 1'b0, 5, dc);
        for (int unsigned i = 0; i < 4; i++) begin
            chk("poke_ignored", {AR_VALID, o_busy}, 0);
            tick();
        end

        // unstalled write latency
        do_write({$urandom, $urandom}, rand_block(), 0, 0, 2'b00, 1'b0, NONE, dc);
        chk("wr_latency", dc, 19);
        tick();

        // simultaneous requests: write first, held read afterwards
        do_write(64'h0000_0000_8000_00C0, rand_block(), 1, 2, 2'b00, 1'b1, NONE, dc);
        fill_words();
        do_read(64'h0000_0000_9000_0100, 2, 2, NB - 1, NONE, NONE, dc);

        // randomized mix
        for (int unsigned it = 0; it < 6; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write({$urandom, $urandom}, rand_block(), $urandom_range(0, 3), 2,
                         2'b00, 1'b0, NONE, dc);
            end else begin
                fill_words();
                do_read({$urandom, $urandom}, $urandom_range(0, 3), 3, NB - 1, NONE, NONE, dc);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // reset during read beat 7, then a clean read
        fill_words();
        do_read(64'h4000, 0, 1, NB - 1, NONE, 7, dc);
        fill_words();
        do_read(64'h5008, 1, 1, NB - 1, NONE, NONE, dc);

        // error-related cases (o_error only rises when the check macro is defined)
        do_write(64'h6000, rand_block(), 0, 0, 2'b10, 1'b0, NONE, dc);
        tick();
        fill_words();
        do_read(64'h7000, 0, 0, NB - 1, 5, NONE, dc);
        fill_words();
        do_read(64'h7040, 0, 1, 11, NONE, NONE, dc);
        fill_words();
        do_read(64'h7080, 0, 1, NB + 1, NONE, NONE, dc);
        fill_words();
        do_read(64'h70C0, 0, 0, NB - 1, NONE, NONE, dc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
